// File: rtl/dmem_access_unit.sv
// MEM-stage data memory access engine: registered request/response handshake with
// byte-lane alignment, load extension, misalignment detection and response timeout.
module dmem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [DATA_W/8-1:0] dmem_wmask,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_resp,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   load_data,
  output logic                misaligned,
  output logic                timeout_err,
  output logic [DATA_W/8-1:0] rmask,
  output logic [DATA_W/8-1:0] wmask
);

  // state | meaning
  // IDLE  | waiting for a load/store from EX/MEM
  // BUSY  | strobes asserted, waiting for dmem_resp or timeout
  // DONE  | completion cycle, result and flags presented
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT) + 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic             killed;
  logic             mis_r;
  logic             to_r;
  logic             lat_load;
  logic [2:0]       lat_f3;
  logic [OFF_W-1:0] lat_off;
  logic [CNT_W-1:0] wait_cnt;

  logic [OFF_W-1:0]  off;
  logic [2:0]        off3;
  logic              illegal;
  logic              unaligned;
  logic              misal;
  logic              accept;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] ld_ext;
  logic              ext_msb;

  assign off    = req_addr[OFF_W-1:0];
  assign off3   = 3'(off);
  assign accept = req_valid & (req_load | req_store) & ~flush;

  always_comb begin
    illegal = 1'b0;
    if (req_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        3'b011, 3'b110:                         illegal = (DATA_W != 64);
        default:                                illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        3'b011:                 illegal = (DATA_W != 64);
        default:                illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b00:   unaligned = 1'b0;
      2'b01:   unaligned = off3[0];
      2'b10:   unaligned = |off3[1:0];
      default: unaligned = |off3;
    endcase
  end

  assign misal = illegal | unaligned;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i >= int'(off3)) && (i < int'(off3) + (1 << funct3[1:0]));
    end
  end

  assign wdata_sh = req_wdata << {off, 3'b000};

  // Extension is driven by the latched request since the live inputs have moved on.
  always_comb begin
    rd_sh = dmem_rdata >> {lat_off, 3'b000};
    case (lat_f3[1:0])
      2'b00:   ext_msb = rd_sh[7];
      2'b01:   ext_msb = rd_sh[15];
      2'b10:   ext_msb = rd_sh[31];
      default: ext_msb = 1'b0;
    endcase
    ld_ext = rd_sh;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= (8 << lat_f3[1:0])) ld_ext[i] = ext_msb & ~lat_f3[2];
    end
  end

  assign stall       = ((state == S_IDLE) & accept) | (state == S_BUSY);
  assign resp_valid  = (state == S_DONE) & ~killed;
  assign misaligned  = mis_r & ~killed;
  assign timeout_err = to_r & ~killed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      killed     <= 1'b0;
      mis_r      <= 1'b0;
      to_r       <= 1'b0;
      lat_load   <= 1'b0;
      lat_f3     <= '0;
      lat_off    <= '0;
      wait_cnt   <= '0;
      dmem_addr  <= '0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      rmask      <= '0;
      wmask      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          killed <= 1'b0;
          if (accept) begin
            load_data <= '0;
            if (misal) begin
              state <= S_DONE;
              mis_r <= 1'b1;
              rmask <= '0;
              wmask <= '0;
            end else begin
              state      <= S_BUSY;
              lat_load   <= req_load;
              lat_f3     <= funct3;
              lat_off    <= off;
              wait_cnt   <= '0;
              dmem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              dmem_read  <= req_load;
              dmem_write <= req_store;
              dmem_wmask <= req_store ? mask : '0;
              dmem_wdata <= wdata_sh;
              rmask      <= req_load ? mask : '0;
              wmask      <= req_store ? mask : '0;
            end
          end
        end
        S_BUSY: begin
          if (flush) killed <= 1'b1;
          if (dmem_resp) begin
            state      <= S_DONE;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (lat_load) load_data <= ld_ext;
          end else if ((TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            state      <= S_DONE;
            to_r       <= 1'b1;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            load_data  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          killed <= 1'b0;
          mis_r  <= 1'b0;
          to_r   <= 1'b0;
          rmask  <= '0;
          wmask  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (no timeout) share stimulus; completions are checked by per-instance scoreboards.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid32, req_valid64;
  logic        req_load, req_store;
  logic [2:0]  funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        flush;
  logic [63:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] dmem_addr32, dmem_addr64;
  logic        dmem_read32, dmem_read64, dmem_write32, dmem_write64;
  logic [3:0]  dmem_wmask32, rmask32, wmask32;
  logic [7:0]  dmem_wmask64, rmask64, wmask64;
  logic [31:0] dmem_wdata32, load_data32;
  logic [63:0] dmem_wdata64, load_data64;
  logic        stall32, stall64, resp_valid32, resp_valid64;
  logic        misaligned32, misaligned64, timeout_err32, timeout_err64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid32), .req_load(req_load),
    .req_store(req_store), .funct3(funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .flush(flush), .dmem_addr(dmem_addr32),
    .dmem_read(dmem_read32), .dmem_write(dmem_write32), .dmem_wmask(dmem_wmask32),
    .dmem_wdata(dmem_wdata32), .dmem_rdata(dmem_rdata[31:0]), .dmem_resp(dmem_resp),
    .stall(stall32), .resp_valid(resp_valid32), .load_data(load_data32),
    .misaligned(misaligned32), .timeout_err(timeout_err32), .rmask(rmask32),
    .wmask(wmask32)
  );

  dmem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid64), .req_load(req_load),
    .req_store(req_store), .funct3(funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .dmem_addr(dmem_addr64),
    .dmem_read(dmem_read64), .dmem_write(dmem_write64), .dmem_wmask(dmem_wmask64),
    .dmem_wdata(dmem_wdata64), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall64), .resp_valid(resp_valid64), .load_data(load_data64),
    .misaligned(misaligned64), .timeout_err(timeout_err64), .rmask(rmask64),
    .wmask(wmask64)
  );

  typedef struct {
    logic [63:0] ld;
    logic        mis;
    logic        to;
    logic [7:0]  rm;
    logic [7:0]  wm;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  // Observation mux so one driver task serves both instances.
  logic        sel;
  logic        o_stall, o_read, o_write;
  logic [31:0] o_daddr;
  logic [63:0] o_dwdata;
  logic [7:0]  o_dwmask;

  always_comb begin
    o_stall  = sel ? stall64 : stall32;
    o_read   = sel ? dmem_read64 : dmem_read32;
    o_write  = sel ? dmem_write64 : dmem_write32;
    o_daddr  = sel ? dmem_addr64 : dmem_addr32;
    o_dwdata = sel ? dmem_wdata64 : {32'b0, dmem_wdata32};
    o_dwmask = sel ? dmem_wmask64 : {4'b0, dmem_wmask32};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid32) begin
      if (q32.size() == 0) begin
        chk("dut32_unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("dut32_load_data", {32'b0, load_data32}, e.ld);
        chk("dut32_misaligned", {63'b0, misaligned32}, {63'b0, e.mis});
        chk("dut32_timeout_err", {63'b0, timeout_err32}, {63'b0, e.to});
        chk("dut32_rmask", {60'b0, rmask32}, {56'b0, e.rm});
        chk("dut32_wmask", {60'b0, wmask32}, {56'b0, e.wm});
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid64) begin
      if (q64.size() == 0) begin
        chk("dut64_unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("dut64_load_data", load_data64, e.ld);
        chk("dut64_misaligned", {63'b0, misaligned64}, {63'b0, e.mis});
        chk("dut64_timeout_err", {63'b0, timeout_err64}, {63'b0, e.to});
        chk("dut64_rmask", {56'b0, rmask64}, {56'b0, e.rm});
        chk("dut64_wmask", {56'b0, wmask64}, {56'b0, e.wm});
      end
    end
  end

  // One access; w = BUSY cycle that carries dmem_resp (0: no response),
  // fl = BUSY cycle with flush (0: none). Called and returns at posedge+1.
  task automatic run(input logic s, input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input int w, input int fl, input logic emis, input logic eto,
                     input logic [63:0] eld, input logic [7:0] erm, input logic [7:0] ewm,
                     input logic [31:0] edaddr, input logic [63:0] edw);
    exp_t e;
    int   n;
    e.ld = eld; e.mis = emis; e.to = eto; e.rm = erm; e.wm = ewm;
    if (fl == 0) begin
      if (s) q64.push_back(e);
      else   q32.push_back(e);
    end
    sel = s;
    req_load = ld; req_store = st; funct3 = f3; req_addr = addr; req_wdata = wd;
    if (s) req_valid64 = 1'b1;
    else   req_valid32 = 1'b1;
    @(negedge clk);
    chk("stall_accept", {63'b0, o_stall}, 64'd1);
    @(posedge clk); #1;
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    if (!emis) begin
      n = (w == 0) ? 4 : w;
      for (int k = 1; k <= n; k++) begin
        if (k == w) begin
          dmem_resp = 1'b1;
          dmem_rdata = rd;
        end
        flush = (k == fl);
        @(negedge clk);
        chk("read_busy", {63'b0, o_read}, {63'b0, ld});
        chk("write_busy", {63'b0, o_write}, {63'b0, st});
        chk("stall_busy", {63'b0, o_stall}, 64'd1);
        chk("dmem_addr", {32'b0, o_daddr}, {32'b0, edaddr});
        if (st && k == 1) begin
          chk("dmem_wdata", o_dwdata, edw);
          chk("dmem_wmask", {56'b0, o_dwmask}, {56'b0, ewm});
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        flush = 1'b0;
      end
    end
    @(negedge clk);
    chk("read_done", {63'b0, o_read}, 64'd0);
    chk("write_done", {63'b0, o_write}, 64'd0);
    chk("stall_done", {63'b0, o_stall}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_load = 1'b0; req_store = 1'b0; funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read32", {63'b0, dmem_read32}, 64'd0);
    chk("rst_stall32", {63'b0, stall32}, 64'd0);
    chk("rst_resp32", {63'b0, resp_valid32}, 64'd0);
    chk("rst_load32", {32'b0, load_data32}, 64'd0);
    chk("rst_rmask64", {56'b0, rmask64}, 64'd0);
    chk("rst_write64", {63'b0, dmem_write64}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 32-bit instance
    run(0, 1, 0, 3'b010, 32'h1000, 64'h0, 64'hDEADBEEF, 1, 0, 0, 0, 64'hDEADBEEF, 8'hF, 8'h0, 32'h1000, 64'h0);
    run(0, 1, 0, 3'b000, 32'h1003, 64'h0, 64'h80FFFF00, 1, 0, 0, 0, 64'hFFFFFF80, 8'h8, 8'h0, 32'h1000, 64'h0);
    run(0, 1, 0, 3'b100, 32'h1003, 64'h0, 64'h80FFFF00, 1, 0, 0, 0, 64'h00000080, 8'h8, 8'h0, 32'h1000, 64'h0);
    run(0, 0, 1, 3'b001, 32'h2002, 64'h0000ABCD, 64'h0, 2, 0, 0, 0, 64'h0, 8'h0, 8'hC, 32'h2000, 64'hABCD0000);
    run(0, 0, 1, 3'b001, 32'h2003, 64'h0000ABCD, 64'h0, 0, 0, 1, 0, 64'h0, 8'h0, 8'h0, 32'h0, 64'h0);
    run(0, 1, 0, 3'b001, 32'h1002, 64'h0, 64'h80011234, 3, 0, 0, 0, 64'hFFFF8001, 8'hC, 8'h0, 32'h1000, 64'h0);
    run(0, 1, 0, 3'b101, 32'h1002, 64'h0, 64'h80011234, 1, 0, 0, 0, 64'h00008001, 8'hC, 8'h0, 32'h1000, 64'h0);
    run(0, 0, 1, 3'b000, 32'h3001, 64'h12345678, 64'h0, 1, 0, 0, 0, 64'h0, 8'h0, 8'h2, 32'h3000, 64'h34567800);
    run(0, 1, 0, 3'b111, 32'h1000, 64'h0, 64'h0, 0, 0, 1, 0, 64'h0, 8'h0, 8'h0, 32'h0, 64'h0);
    run(0, 1, 0, 3'b011, 32'h1000, 64'h0, 64'h0, 0, 0, 1, 0, 64'h0, 8'h0, 8'h0, 32'h0, 64'h0);
    run(0, 1, 0, 3'b010, 32'h4000, 64'h0, 64'h0, 0, 0, 0, 1, 64'h0, 8'hF, 8'h0, 32'h4000, 64'h0);
    run(0, 1, 0, 3'b010, 32'h1001, 64'h0, 64'h0, 0, 0, 1, 0, 64'h0, 8'h0, 8'h0, 32'h0, 64'h0);
    run(0, 1, 0, 3'b010, 32'h1000, 64'h0, 64'h11112222, 2, 1, 0, 0, 64'h0, 8'h0, 8'h0, 32'h1000, 64'h0);
    run(0, 1, 0, 3'b010, 32'h1000, 64'h0, 64'h33334444, 1, 0, 0, 0, 64'h33334444, 8'hF, 8'h0, 32'h1000, 64'h0);

    // reset while BUSY
    sel = 1'b0;
    req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; req_addr = 32'h6000;
    req_valid32 = 1'b1;
    @(posedge clk); #1;
    req_valid32 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("busy_before_rst", {63'b0, dmem_read32}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_read", {63'b0, dmem_read32}, 64'd0);
    chk("rst_busy_stall", {63'b0, stall32}, 64'd0);
    chk("rst_busy_resp", {63'b0, resp_valid32}, 64'd0);
    chk("rst_busy_load", {32'b0, load_data32}, 64'd0);
    chk("rst_busy_rmask", {60'b0, rmask32}, 64'd0);
    chk("rst_busy_addr", {32'b0, dmem_addr32}, 64'd0);
    @(posedge clk); #1;
    run(0, 0, 1, 3'b010, 32'h5004, 64'hCAFEF00D, 64'h0, 1, 0, 0, 0, 64'h0, 8'h0, 8'hF, 32'h5004, 64'hCAFEF00D);

    // 64-bit instance
    run(1, 1, 0, 3'b110, 32'h104, 64'h0, 64'h8000000112345678, 1, 0, 0, 0, 64'h0000000080000001, 8'hF0, 8'h0, 32'h100, 64'h0);
    run(1, 1, 0, 3'b010, 32'h104, 64'h0, 64'h8000000112345678, 2, 0, 0, 0, 64'hFFFFFFFF80000001, 8'hF0, 8'h0, 32'h100, 64'h0);
    run(1, 0, 1, 3'b011, 32'h208, 64'h0123456789ABCDEF, 64'h0, 1, 0, 0, 0, 64'h0, 8'h0, 8'hFF, 32'h208, 64'h0123456789ABCDEF);
    run(1, 1, 0, 3'b011, 32'h100, 64'h0, 64'hFEDCBA9876543210, 3, 0, 0, 0, 64'hFEDCBA9876543210, 8'hFF, 8'h0, 32'h100, 64'h0);
    run(1, 1, 0, 3'b001, 32'h106, 64'h0, 64'h8765000000000000, 1, 0, 0, 0, 64'hFFFFFFFFFFFF8765, 8'hC0, 8'h0, 32'h100, 64'h0);
    run(1, 0, 1, 3'b010, 32'h10C, 64'h00000000AABBCCDD, 64'h0, 2, 0, 0, 0, 64'h0, 8'h0, 8'hF0, 32'h108, 64'hAABBCCDD00000000);
    run(1, 1, 0, 3'b011, 32'h104, 64'h0, 64'h0, 0, 0, 1, 0, 64'h0, 8'h0, 8'h0, 32'h0, 64'h0);
    run(1, 1, 0, 3'b100, 32'h107, 64'h0, 64'h9A00000000000000, 1, 0, 0, 0, 64'h000000000000009A, 8'h80, 8'h0, 32'h100, 64'h0);

    repeat (2) @(posedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
